// File: rtl/lsu_controller.sv
// Load/store sequencer: one word-aligned req/ack transaction per LOAD/STORE, with stall, timeout abort and load formatting.
// Optional feature: define MISALIGN_TRAP_EN to abort misaligned halfword/word accesses without touching the bus.
module lsu_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        rd_we,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_reg;
  logic [7:0]  count_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  addr_lo_reg;
  logic        trap;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 1x word.
  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = rdata[{lo, 3'b000} +: 8];
    h   = lo[1] ? rdata[31:16] : rdata[15:0];
    res = rdata;
    case (f3[1:0])
      2'b00:   res = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   res = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = ((funct3[1:0] == 2'b01) && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign stall = ((state_reg == IDLE) && start) || (state_reg == REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= 8'd0;
      funct3_reg  <= 3'd0;
      addr_lo_reg <= 2'd0;
      done        <= 1'b0;
      rd_we       <= 1'b0;
      load_data   <= 32'd0;
      bus_err     <= 1'b0;
      misalign    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wstrb   <= 4'd0;
      mem_wdata   <= 32'd0;
    end else begin
      // Completion flags are single-cycle pulses; they are only raised on entry to RESP.
      done     <= 1'b0;
      rd_we    <= 1'b0;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (trap) begin
              state_reg <= RESP;
              done      <= 1'b1;
              misalign  <= 1'b1;
              load_data <= 32'd0;
            end else begin
              state_reg   <= REQ;
              count_reg   <= 8'd0;
              funct3_reg  <= funct3;
              addr_lo_reg <= addr[1:0];
              mem_req     <= 1'b1;
              mem_we      <= is_store;
              mem_addr    <= {addr[31:2], 2'b00};
              mem_wstrb   <= is_store ? st_wstrb : 4'b0000;
              mem_wdata   <= st_wdata;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            rd_we     <= !mem_we;
            if (!mem_we) begin
              load_data <= format_load(funct3_reg, addr_lo_reg, mem_rdata);
            end
          end else if (count_reg == 8'(TIMEOUT_CYCLES - 1)) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= 32'd0;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Randomized + directed bench for lsu_controller against a transaction-level reference model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_controller;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        stall, done, rd_we, bus_err, misalign;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] load_model = 32'd0;

  lsu_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .stall(stall), .done(done), .rd_we(rd_we),
    .load_data(load_data), .bus_err(bus_err), .misalign(misalign), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: size from funct3[1:0] (0 byte, 1 half, 2/3 word); lanes by shifting.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int wt);
    int size, exp_req, req_n, stall_n, cyc;
    logic trap, berr, got_done, first;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load, v;
    size = (f3[1:0] == 2'b00) ? 0 : (f3[1:0] == 2'b01) ? 1 : 2;
`ifdef MISALIGN_TRAP_EN
    trap = (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    berr    = !trap && (wt >= TMO);
    exp_req = trap ? 0 : (wt < TMO ? wt + 1 : TMO);
    if (size == 0) begin
      e_strb  = 4'(1 << a[1:0]);
      e_wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
      v       = (rd >> (8 * a[1:0])) & 32'hFF;
      e_load  = (!f3[2] && v[7]) ? (v | 32'hFFFF_FF00) : v;
    end else if (size == 1) begin
      e_strb  = a[1] ? 4'b1100 : 4'b0011;
      e_wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
      v       = (rd >> (16 * a[1])) & 32'hFFFF;
      e_load  = (!f3[2] && v[15]) ? (v | 32'hFFFF_0000) : v;
    end else begin
      e_strb  = 4'b1111;
      e_wdata = sd;
      e_load  = rd;
    end
    if (!st) e_strb = 4'b0000;

    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mem_rdata = rd; mem_ack = 1'b0;
    #1;
    chk("stall_accept", stall, 1);
    req_n = 0; stall_n = 1; cyc = 0; got_done = 1'b0; first = 1'b1;
    while (!got_done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req) begin
        req_n++;
        if (first) begin
          chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
          chk("mem_we", mem_we, st);
          chk("mem_wstrb", mem_wstrb, e_strb);
          if (st) chk("mem_wdata", mem_wdata, e_wdata);
          first = 1'b0;
        end
        mem_ack = (req_n == wt + 1);
      end else begin
        mem_ack = 1'b0;
      end
      if (stall) stall_n++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0; mem_ack = 1'b0;
    if (!got_done) chk("done_seen", 0, 1);
    if (trap || berr) load_model = 32'd0;
    else if (!st) load_model = e_load;
    chk("latency", cyc, exp_req + 1);
    chk("req_cycles", req_n, exp_req);
    chk("stall_cycles", stall_n, exp_req + 1);
    chk("bus_err", bus_err, berr);
    chk("misalign", misalign, trap);
    chk("rd_we", rd_we, !st && !berr && !trap);
    chk("load_data", load_data, load_model);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    $display("txn st=%0d f3=%0d addr=%h wait=%0d -> load_data=%h bus_err=%0d misalign=%0d cyc=%0d",
             st, f3, a, wt, load_data, berr, trap, cyc);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_stall_lo", stall, 0);
    start = 1'b1; #1;
    chk("rst_stall_hi", stall, 1);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan
    run_txn(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);         // LB sign-extend
    run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 3);         // SH, 3 waits
    run_txn(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'h1111_2222, 1000);      // LW timeout
    run_txn(1'b0, 3'd2, 32'h0000_0006, 32'd0, 32'hCAFE_F00D, 0);         // LW misaligned
    run_txn(1'b0, 3'd5, 32'h0000_0002, 32'd0, 32'h9ABC_0000, 0);         // LHU
    run_txn(1'b0, 3'd1, 32'h0000_0002, 32'd0, 32'h9ABC_0000, 0);         // LH
    run_txn(1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'h5555_AAAA, TMO - 1);   // ack on last cycle
    run_txn(1'b1, 3'd0, 32'h0000_0301, 32'h0000_00A5, 32'd0, TMO);       // store timeout

    // Reset during the second REQ cycle
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("mrst_req1", mem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("mrst_req_drop", mem_req, 0);
    chk("mrst_no_done", done, 0);
    chk("mrst_stall", stall, 0);
    rst_n = 1'b1;
    load_model = 32'd0;
    @(posedge clk); #1;
    chk("mrst_no_done2", done, 0);
    run_txn(1'b0, 3'd4, 32'h0000_0041, 32'd0, 32'h0000_F700, 2);         // LBU after reset

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic st;
      logic [2:0] f3;
      int sel, wt;
      st  = 1'($urandom_range(0, 1));
      f3  = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      wt  = (sel == 9) ? 1000 : (sel == 8) ? TMO - 1 : sel % 4;
      run_txn(st, f3, $urandom, $urandom, $urandom, wt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu_controller.md
# lsu_controller

Multi-cycle load/store sequencer for the RV32E core. It accepts a decoded LOAD/STORE from the execute stage, stalls the core, and runs one word-aligned transaction on the data-memory req/ack bus. It then returns a formatted, sign- or zero-extended load result with a one-cycle register-file write strobe. It sits between the ALU address output and the data memory, beside the decoder.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without mem_ack before abort; legal range 1..255.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  a LOAD/STORE is present in execute; level, held while stall=1.
- is_store  in  1  1=STORE, 0=LOAD.
- funct3  in  3  instruction funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr  in  32  effective address (rs1 + immediate).
- store_data  in  32  rs2 value.
- stall  out  1  freeze PC and execute stage.
- done  out  1  one-cycle pulse when the access completes or aborts.
- rd_we  out  1  one-cycle load write strobe; coincident with done.
- load_data  out  32  formatted load result; valid while done=1.
- bus_err  out  1  timeout abort flag; valid while done=1.
- misalign  out  1  misaligned-access flag; valid while done=1.
- mem_req  out  1  bus request.
- mem_we  out  1  1=write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wstrb  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  target completion; sampled only while mem_req=1.
- mem_rdata  in  32  read word; valid when mem_ack=1 on a read.

## Operation
- States: IDLE, REQ, RESP.
- IDLE→REQ: start=1 and the access is not trapped. Register mem_we, mem_addr, mem_wstrb, mem_wdata, funct3, and addr[1:0].
- REQ: mem_req=1 with stable fields. mem_ack=1 → RESP; on a read, capture the formatted mem_rdata.
- REQ timeout: the timeout counter reaches TIMEOUT_CYCLES without ack → RESP with bus_err=1.
- RESP: done=1, lasting one cycle, then → IDLE. rd_we=!is_store & !bus_err & !misalign.
- stall = (IDLE & start) | REQ. stall is 0 in RESP, so the core advances at the end of RESP. start is ignored in RESP.
- Store formatting:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata=d, wstrb=1111.
  - Store funct3=3 behaves as SW.
  - Loads: wstrb=0000.
- Load formatting:
  - Select byte rdata[8*addr[1:0]+:8] or halfword rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Load funct3 3/6/7 behaves as LW.
- load_data holds its value until the next capture; it is 0 after bus_err or misalign aborts.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE; counter=0; all outputs 0, except stall=start (combinational).
- Reset mid-REQ: mem_req drops after that edge. No done pulse is produced.
- Minimum latency with zero-wait ack (ack in the first REQ cycle):
  - Edge 0 accepts.
  - Cycle 1 is REQ.
  - Cycle 2 is RESP with done=1.
  - stall is high for 2 cycles.
- Each wait cycle (mem_ack=0 in REQ) adds one cycle.
- The counter clears on entry to REQ and increments each REQ cycle with ack=0. The abort fires after TIMEOUT_CYCLES consecutive ack-low cycles.
- Ack in the same cycle the counter would expire wins: a normal completion, bus_err=0.
- mem_req, mem_addr, mem_we, mem_wstrb, and mem_wdata are registered and glitch-free. mem_req is never reasserted in RESP.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned halfword (addr[0]=1) or word (addr[1:0]≠0) accesses go IDLE→RESP directly with no mem_req.
  - misalign=1, rd_we=0, load_data=0; the store has no effect.
  - Latency is 1 cycle: stall is high for the IDLE cycle only.
- MISALIGN_TRAP_EN undefined:
  - The offending low address bits are ignored (halfword uses addr[1], word uses none).
  - Accesses proceed normally; misalign is tied 0.

## Test plan
- LB, addr=0x1003, mem_rdata=0x80FF_1234 with zero-wait ack → done in cycle 2, load_data=0xFFFF_FF80, rd_we=1, mem_addr=0x1000.
- SH, addr=0x2002, store_data=0x0000_BEEF, ack after 3 wait cycles → mem_wdata=0xBEEF_BEEF, mem_wstrb=1100, mem_we=1, stall high 5 cycles, rd_we=0.
- LW with mem_ack never asserted, TIMEOUT_CYCLES=16 → mem_req high exactly 16 cycles, then done=1, bus_err=1, rd_we=0, load_data=0.
- LW, addr=0x0000_0006 with MISALIGN_TRAP_EN → no mem_req, done next cycle, misalign=1. Without the macro → mem_addr=0x4, normal completion, misalign=0.
- LHU, addr=0x0002, mem_rdata=0x9ABC_0000 → load_data=0x0000_9ABC. LH, same data → 0xFFFF_9ABC.
- rst_n low during the second REQ cycle → mem_req=0 and IDLE after that edge, no done pulse. A new start afterward completes normally.
